hamming_secded_rx: RTL and testbench
====================================

Name: hamming_secded_rx

Overview:
- Parametrised successor to the fixed (7,4)…(12,8) bit-serial receiver.
- Recovers an asynchronous start/stop-framed Hamming SEC-DED codeword from a single serial line, using a programmable baud divider and mid-bit sampling.
- Corrects single-bit errors, flags double-bit errors, checks framing, and presents the decoded data word on a valid/ready output handshake.
- Sits between the board RX pin and the downstream decrypt/consumer logic.

Parameters:
- K, 8: data bits per codeword (2..26).
- P, 4: Hamming check bits; the requirement 2^P >= K+P+1 is checked at elaboration.
- DIV, 16: clocks per bit period (>=4, even).
- N (localparam), K+P+1: codeword bits, including overall parity.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: synchronous active-low reset, sampled on rising edge of clk.
- data_in, input, 1: serial line, idle high, asynchronous to clk.
- data_out, output, K: decoded (corrected) data word.
- out_valid, output, 1: data_out and status are valid.
- out_ready, input, 1: consumer accepts the word when out_valid && out_ready.
- syndrome, output, P: raw Hamming syndrome of the held word.
- corrected, output, 1: a single-bit error was corrected in the held word.
- uncorrectable, output, 1: a double error was detected; data_out is raw and uncorrected.
- frame_err, output, 1: one-clock pulse when the stop bit samples low.
- overrun, output, 1: one-clock pulse when a good frame is dropped because the output is still occupied.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs are 0.
  - FSM returns to IDLE and all counters clear.
  - The synchroniser flops reset to 1.
  - Reset asserted mid-frame aborts the frame with no pulses.
- Input path: data_in passes through a 2-flop synchroniser into rx_s. Falling-edge detect uses rx_s versus its previous value.
- Codeword layout:
  - Bit 0 is overall even parity; bits 1..N-1 are Hamming positions.
  - Check bits sit at positions 1, 2, 4, … 2^(P-1).
  - Data bits fill the remaining positions in ascending order, data bit 0 at position 3.
  - Transmission is LSB first: bit 0 immediately after the start bit.
- FSM states:
  - IDLE: a falling edge on rx_s moves to START with bit counter = DIV/2-1.
  - START: when the counter reaches 0, sample rx_s. If 0, go to DATA (counter = DIV-1, bit index = 0). If 1, treat it as a glitch and return to IDLE silently.
  - DATA: on each counter expiry, shift rx_s into codeword[bit index] and reload the counter to DIV-1. After bit N-1, go to STOP.
  - STOP: on counter expiry, sample rx_s.
    - If 0: pulse frame_err, discard the frame, go to WAIT_HIGH.
    - If 1: decode and go to IDLE.
  - WAIT_HIGH: stay until rx_s = 1, then go to IDLE. This prevents a break condition from retriggering.
- Decode (combinational on the stop-sample cycle, registered on the same edge):
  - syn = XOR of the indices of all set bits in positions 1..N-1.
  - par = XOR of all N bits.
  - syn=0, par=0: clean.
  - par=1 and syn<=N-1: flip bit syn (syn=0 means the parity bit flipped); set corrected=1.
  - par=0, syn!=0: set uncorrectable=1 and leave the data unmodified.
  - par=1, syn>N-1: set uncorrectable=1.
- Latency: out_valid rises on the clk edge after the stop-bit sample edge.
- Output handshake:
  - data_out, syndrome, corrected and uncorrectable are held stable while out_valid=1.
  - out_valid clears on the cycle after a handshake.
  - If a new good frame completes in the same cycle as a handshake, the new word loads and out_valid stays 1.
  - If a new good frame completes while out_valid=1 and out_ready=0: keep the old word, pulse overrun, drop the new word.
- A frame error never touches the output registers.
- The receiver keeps accepting frames while out_valid=1; there is no backpressure to the line.

Test Plan:
1. Clean frame (K=4, P=3, DIV=4): send data 4'b1011 as codeword 8'hAA → out_valid 1 clk after the stop sample, data_out=4'b1011, syndrome=0, corrected=0, uncorrectable=0.
2. Single error: send 8'h8A (position 5 flipped) → data_out=4'b1011, syndrome=3'd5, corrected=1. Repeat with 8'hAB (parity bit flipped) → syndrome=0, corrected=1, data_out=4'b1011.
3. Double error: send 8'hCA (positions 5 and 6 flipped) → syndrome=3'd3, uncorrectable=1, corrected=0.
4. Framing: send 8'hAA with stop bit 0 → frame_err pulses for 1 clk, out_valid stays 0. Hold the line low for 3 bit periods, then release → no spurious frame. A following clean 8'hAA is received correctly.
5. Glitch and overrun:
   - Drive a 1-clk low pulse on the idle line → busy returns to 0, no output.
   - Send two frames with out_ready=0 → first word is held and overrun pulses once.
   - Then raise out_ready → handshake completes and out_valid drops the next cycle.
6. Reset mid-frame: assert rst_n=0 during DATA bit 3 → all outputs 0 and busy=0 on the next edge. A following clean frame decodes correctly.

Source files
------------

// File: rtl/hamming_secded_rx.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_secded_rx
//  Purpose  : Bit-serial receiver for start/stop framed Hamming SEC-DED
//             codewords. It oversamples the line with a programmable baud
//             divider and samples each bit near its middle. Single-bit errors
//             are corrected, double-bit errors are flagged, and the stop bit
//             is checked. The decoded word is offered on a valid/ready port.
//  Ports    : clk, rst_n (sync, active low)   - clock / reset
//             data_in                         - async serial line, idle high
//             data_out[K], out_valid, out_ready - decoded word handshake
//             syndrome[P], corrected, uncorrectable - status of held word
//             frame_err, overrun                - one-clock event pulses
//             busy                              - receiver not idle
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module hamming_secded_rx #(
  parameter int K   = 8,
  parameter int P   = 4,
  parameter int DIV = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         data_in,
  output logic [K-1:0] data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [P-1:0] syndrome,
  output logic         corrected,
  output logic         uncorrectable,
  output logic         frame_err,
  output logic         overrun,
  output logic         busy
);

  localparam int N  = K + P + 1;
  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(N);

  localparam logic [CW-1:0] C_CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] C_CNT_FULL = CW'(DIV - 1);
  localparam logic [IW-1:0] C_IDX_LAST = IW'(N - 1);

  // Every check-bit position must exist and the syndrome must be able to
  // address every Hamming position.
  generate
    if ((2 ** P) < (K + P + 1)) begin : g_bad_p_small
      $error("hamming_secded_rx: 2**P must be >= K+P+1");
    end
    if ((2 ** (P - 1)) > (K + P)) begin : g_bad_p_large
      $error("hamming_secded_rx: P too large, top check bit falls outside codeword");
    end
    if ((DIV < 4) || ((DIV % 2) != 0)) begin : g_bad_div
      $error("hamming_secded_rx: DIV must be even and >= 4");
    end
  endgenerate

  // Codeword position of data bit d: d-th non-power-of-two index in 1..N-1.
  function automatic int data_pos(input int d);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int i = 1; i < N; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (cnt == d) pos = i;
        cnt = cnt + 1;
      end
    end
    return pos;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic          sync1_q, rx_s_q, rx_prev_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  cw_q, cw_d;
  logic [K-1:0]  data_q, data_d;
  logic [P-1:0]  syn_q, syn_d;
  logic          corr_q, corr_d;
  logic          unc_q, unc_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  logic          stop_good;
  logic          stop_bad;

  // --------------------------------------------------------------------------
  // Decode of the captured codeword (only consumed on the stop-sample cycle)
  // --------------------------------------------------------------------------
  logic [P-1:0]  syn_w;
  logic          par_w;
  logic          in_range_w;
  logic [N-1:0]  fixed_w;
  logic          corr_w;
  logic          unc_w;
  logic [K-1:0]  dec_data_w;

  always_comb begin
    syn_w      = '0;
    par_w      = ^cw_q;
    in_range_w = 1'b0;
    fixed_w    = cw_q;
    for (int i = 1; i < N; i++) begin
      if (cw_q[i]) syn_w = syn_w ^ P'(i);
    end
    // The flip is only applied when the parity says an odd number of bits
    // changed; a syndrome beyond the codeword can only come from >1 error.
    for (int i = 0; i < N; i++) begin
      if (syn_w == P'(i)) begin
        in_range_w = 1'b1;
        if (par_w) fixed_w[i] = ~cw_q[i];
      end
    end
    corr_w = par_w & in_range_w;
    unc_w  = par_w ? ~in_range_w : (syn_w != '0);
  end

  generate
    for (genvar d = 0; d < K; d++) begin : g_extract
      localparam int C_POS = data_pos(d);
      assign dec_data_w[d] = fixed_w[C_POS];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    cw_d      = cw_q;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d = S_START;
          cnt_d   = C_CNT_HALF;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!rx_s_q) begin
            state_d = S_DATA;
            cnt_d   = C_CNT_FULL;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          for (int i = 0; i < N; i++) begin
            if (idx_q == IW'(i)) cw_d[i] = rx_s_q;
          end
          cnt_d = C_CNT_FULL;
          if (idx_q == C_IDX_LAST) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            stop_good = 1'b1;
            state_d   = S_IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_d   = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WAIT_HIGH: begin
        // A held-low line (break) must not look like a fresh start bit.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output holding register and handshake
  // --------------------------------------------------------------------------
  always_comb begin
    data_d  = data_q;
    syn_d   = syn_q;
    corr_d  = corr_q;
    unc_d   = unc_q;
    valid_d = valid_q;
    ferr_d  = stop_bad;
    ovr_d   = 1'b0;
    if (stop_good) begin
      if (!valid_q || out_ready) begin
        data_d  = dec_data_w;
        syn_d   = syn_w;
        corr_d  = corr_w;
        unc_d   = unc_w;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      cw_q      <= '0;
      data_q    <= '0;
      syn_q     <= '0;
      corr_q    <= 1'b0;
      unc_q     <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync1_q   <= data_in;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      cw_q      <= cw_d;
      data_q    <= data_d;
      syn_q     <= syn_d;
      corr_q    <= corr_d;
      unc_q     <= unc_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_out      = data_q;
  assign syndrome      = syn_q;
  assign corrected     = corr_q;
  assign uncorrectable = unc_q;
  assign out_valid     = valid_q;
  assign frame_err     = ferr_q;
  assign overrun       = ovr_q;
  assign busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hamming_secded_rx
//  Purpose  : Self-checking bench for hamming_secded_rx (K=4, P=3, DIV=4).
//             Expected decodes are queued as frames are sent and compared
//             when the receiver hands the word over.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_secded_rx;

  localparam int K   = 4;
  localparam int P   = 3;
  localparam int DIV = 4;

  typedef struct {
    logic [K-1:0] d;
    logic [P-1:0] s;
    logic         c;
    logic         u;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         data_in = 1'b1;
  logic         out_ready = 1'b1;
  logic [K-1:0] data_out;
  logic         out_valid;
  logic [P-1:0] syndrome;
  logic         corrected;
  logic         uncorrectable;
  logic         frame_err;
  logic         overrun;
  logic         busy;

  int   n_vec = 0;
  int   n_err = 0;
  int   ferr_cnt = 0;
  int   ovr_cnt = 0;
  bit   abort = 1'b0;
  exp_t sb[$];

  hamming_secded_rx #(.K(K), .P(P), .DIV(DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .syndrome     (syndrome),
    .corrected    (corrected),
    .uncorrectable(uncorrectable),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference encoder: data at 3,5,6,7; checks at 1,2,4; overall parity at 0.
  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    c    = '0;
    c[3] = d[0];
    c[5] = d[1];
    c[6] = d[2];
    c[7] = d[3];
    c[1] = ^(c & 8'hAA);
    c[2] = ^(c & 8'hCC);
    c[4] = ^(c & 8'hF0);
    c[0] = ^c[7:1];
    return c;
  endfunction

  // Reference decoder built from per-check-bit parity groups.
  function automatic exp_t model_decode(input logic [7:0] c);
    exp_t       e;
    logic [2:0] s;
    logic [7:0] f;
    s[0] = ^(c & 8'hAA);
    s[1] = ^(c & 8'hCC);
    s[2] = ^(c & 8'hF0);
    f    = c;
    e.s  = s;
    e.c  = 1'b0;
    e.u  = 1'b0;
    if (^c) begin
      f[s] = ~f[s];
      e.c  = 1'b1;
    end else if (s != 3'd0) begin
      e.u = 1'b1;
    end
    e.d = {f[7], f[6], f[5], f[3]};
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    for (int t = 0; t < DIV; t++) begin
      data_in = abort ? 1'b1 : b;
      tick(1);
    end
  endtask

  // Leaves the line at the stop-bit level; caller decides what follows.
  task automatic send_frame(input logic [7:0] cw, input logic stop, input bit expect_out);
    if (expect_out) sb.push_back(model_decode(cw));
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(cw[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    data_in = 1'b1;
    tick(n);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20 * DIV; i++) begin
      if (sb.size() == 0) break;
      tick(1);
    end
    check_eq(tag, sb.size(), 0);
  endtask

  // Scoreboard consumer and event-pulse counters.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_word", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("data_out", data_out, e.d);
          check_eq("syndrome", syndrome, e.s);
          check_eq("corrected", corrected, e.c);
          check_eq("uncorrectable", uncorrectable, e.u);
        end
      end
    end
  end

  initial begin
    int f0;
    int o0;
    logic [7:0] cw;
    logic [3:0] d;
    int p0;
    int p1;

    // Reset state
    tick(3);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_data", data_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pulses", {frame_err, overrun, corrected, uncorrectable}, 0);
    rst_n = 1'b1;
    idle(4);

    // Clean, single-error, parity-bit error and double-error frames
    send_frame(8'hAA, 1'b1, 1'b1); idle(2 * DIV); wait_drain("drain_clean");
    send_frame(8'h8A, 1'b1, 1'b1); idle(2 * DIV); wait_drain("drain_single");
    send_frame(8'hAB, 1'b1, 1'b1); idle(2 * DIV); wait_drain("drain_parity");
    send_frame(8'hCA, 1'b1, 1'b1); idle(2 * DIV); wait_drain("drain_double");

    // Random clean / single / double error frames
    for (int n = 0; n < 8; n++) begin
      d  = 4'($urandom_range(0, 15));
      cw = encode(d);
      p0 = $urandom_range(0, 7);
      p1 = (p0 + $urandom_range(1, 7)) % 8;
      case (n % 3)
        1: cw[p0] = ~cw[p0];
        2: begin cw[p0] = ~cw[p0]; cw[p1] = ~cw[p1]; end
        default: ;
      endcase
      send_frame(cw, 1'b1, 1'b1);
      idle(2 * DIV);
      wait_drain("drain_rand");
    end

    // Framing error followed by a break, then a clean frame
    f0 = ferr_cnt;
    send_frame(8'hAA, 1'b0, 1'b0);
    data_in = 1'b0;
    tick(3 * DIV);
    idle(4 * DIV);
    check_eq("ferr_pulses", ferr_cnt - f0, 1);
    check_eq("ferr_no_valid", out_valid, 0);
    check_eq("ferr_busy", busy, 0);
    send_frame(8'hAA, 1'b1, 1'b1); idle(2 * DIV); wait_drain("drain_after_ferr");

    // One-clock glitch on the idle line
    data_in = 1'b0;
    tick(1);
    data_in = 1'b1;
    tick(2);
    check_eq("glitch_busy_hi", busy, 1);
    tick(3 * DIV);
    check_eq("glitch_busy_lo", busy, 0);
    check_eq("glitch_no_valid", out_valid, 0);

    // Two frames with the consumer stalled: first held, second dropped
    o0 = ovr_cnt;
    out_ready = 1'b0;
    send_frame(8'hAA, 1'b1, 1'b1); idle(2 * DIV);
    send_frame(encode(4'h6), 1'b1, 1'b0); idle(2 * DIV);
    check_eq("ovr_pulses", ovr_cnt - o0, 1);
    check_eq("ovr_held_valid", out_valid, 1);
    check_eq("ovr_held_data", data_out, 4'b1011);
    out_ready = 1'b1;
    tick(1);
    check_eq("hs_valid_drop", out_valid, 0);
    check_eq("hs_drained", sb.size(), 0);

    // Reset mid-frame while a word is held
    out_ready = 1'b0;
    send_frame(8'h8A, 1'b1, 1'b0); idle(2 * DIV);
    check_eq("pre_rst_valid", out_valid, 1);
    check_eq("pre_rst_corr", corrected, 1);
    fork
      send_frame(8'hAA, 1'b1, 1'b0);
      begin
        tick(4 * DIV + DIV / 2);
        check_eq("mid_busy", busy, 1);
        abort   = 1'b1;
        data_in = 1'b1;
        rst_n   = 1'b0;
        tick(1);
        check_eq("mr_valid", out_valid, 0);
        check_eq("mr_data", data_out, 0);
        check_eq("mr_status", {syndrome, corrected, uncorrectable}, 0);
        check_eq("mr_pulses", {frame_err, overrun}, 0);
        check_eq("mr_busy", busy, 0);
        tick(1);
        rst_n = 1'b1;
      end
    join
    abort     = 1'b0;
    out_ready = 1'b1;
    idle(4 * DIV);
    check_eq("post_rst_idle", {busy, out_valid}, 0);
    send_frame(8'hAA, 1'b1, 1'b1); idle(2 * DIV); wait_drain("drain_post_rst");

    check_eq("ferr_total", ferr_cnt, 1);
    check_eq("ovr_total", ovr_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
